score_unit: RTL and testbench

Parametrised BCD score accumulator for the Pac-Man game core, replacing the single-step binary score counter. It takes per-event award strobes from the game logic (pellet, power pellet, ghost), queues simultaneous events, and adds one award per clock. It also tracks the ghost-chain multiplier, a persistent high score, a one-shot extra-life award and saturation. Its outputs feed the HUD digit renderer directly as BCD.

---
 rtl/score_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_score_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/score_unit.sv
// BCD score accumulator: queues pellet/power/ghost award strobes, adds one award per clock,
// and tracks the ghost-chain multiplier, high score, extra-life award, saturation and lost events.
module score_unit #(
    parameter int DIGITS         = 6,
    parameter int PELLET_PTS     = 10,
    parameter int POWER_PTS      = 50,
    parameter int GHOST_BASE     = 200,
    parameter int EXTRA_LIFE_PTS = 10000,
    parameter int PEND_W         = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  game_clear,
    input  logic                  pellet_eaten,
    input  logic                  power_eaten,
    input  logic                  ghost_eaten,
    input  logic                  power_end,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  extra_life,
    output logic                  busy,
    output logic                  saturated,
    output logic                  dropped
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r;
        longint       t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 64'sd10);
            t           = t / 64'sd10;
        end
        return r;
    endfunction

    // An award or threshold wider than the score cannot be represented and counts as overflow.
    function automatic logic too_big(input longint v);
        longint lim;
        lim = 64'sd1;
        for (int i = 0; i < DIGITS; i++) begin
            lim = lim * 64'sd10;
        end
        return (v >= lim);
    endfunction

    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic         c;
        logic [4:0]   d;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (d > 5'd9) begin
                s[4*i +: 4] = 4'(d - 5'd10);
                c           = 1'b1;
            end else begin
                s[4*i +: 4] = d[3:0];
                c           = 1'b0;
            end
        end
        return {c, s};
    endfunction

    // Returns {drop, next_count} for one pending counter.
    function automatic logic [PEND_W:0] pend_step(input logic [PEND_W-1:0] p,
                                                  input logic strobe, input logic consumed);
        logic [PEND_W-1:0] n;
        logic              drop;
        drop = 1'b0;
        if (consumed) begin
            n = strobe ? p : (p - {{(PEND_W-1){1'b0}}, 1'b1});
        end else if (strobe) begin
            if (p == {PEND_W{1'b1}}) begin
                n    = p;
                drop = 1'b1;
            end else begin
                n = p + {{(PEND_W-1){1'b0}}, 1'b1};
            end
        end else begin
            n = p;
        end
        return {drop, n};
    endfunction

    localparam logic [W-1:0] PELLET_BCD = to_bcd(longint'(PELLET_PTS));
    localparam logic [W-1:0] POWER_BCD  = to_bcd(longint'(POWER_PTS));
    localparam logic [W-1:0] GHOST0_BCD = to_bcd(longint'(GHOST_BASE));
    localparam logic [W-1:0] GHOST1_BCD = to_bcd(longint'(GHOST_BASE) * 64'sd2);
    localparam logic [W-1:0] GHOST2_BCD = to_bcd(longint'(GHOST_BASE) * 64'sd4);
    localparam logic [W-1:0] GHOST3_BCD = to_bcd(longint'(GHOST_BASE) * 64'sd8);
    localparam logic [W-1:0] THRESH_BCD = to_bcd(longint'(EXTRA_LIFE_PTS));
    localparam logic PELLET_BIG = too_big(longint'(PELLET_PTS));
    localparam logic POWER_BIG  = too_big(longint'(POWER_PTS));
    localparam logic GHOST0_BIG = too_big(longint'(GHOST_BASE));
    localparam logic GHOST1_BIG = too_big(longint'(GHOST_BASE) * 64'sd2);
    localparam logic GHOST2_BIG = too_big(longint'(GHOST_BASE) * 64'sd4);
    localparam logic GHOST3_BIG = too_big(longint'(GHOST_BASE) * 64'sd8);
    localparam logic THRESH_BIG = too_big(longint'(EXTRA_LIFE_PTS));
    localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

    localparam logic [1:0] SEL_NONE   = 2'd0;
    localparam logic [1:0] SEL_PELLET = 2'd1;
    localparam logic [1:0] SEL_POWER  = 2'd2;
    localparam logic [1:0] SEL_GHOST  = 2'd3;

    logic [W-1:0]      score_r, high_r;
    logic [PEND_W-1:0] pend_pellet_r, pend_power_r, pend_ghost_r;
    logic [1:0]        idx_r;
    logic              armed_r, saturated_r, extra_life_r, busy_r, dropped_r;

    logic [1:0]        sel_s, idx_eff_s, idx_nx_s;
    logic [W-1:0]      award_s, new_score_s;
    logic              award_big_s, sat_hit_s, xl_hit_s;
    logic [W:0]        sum_s;
    logic [PEND_W:0]   pellet_nx_s, power_nx_s, ghost_nx_s;

    // Pick the award for this cycle by priority and value the ghost at the effective chain index.
    always_comb begin
        sel_s = SEL_NONE;
        if (ghost_eaten || (pend_ghost_r != '0)) begin
            sel_s = SEL_GHOST;
        end else if (power_eaten || (pend_power_r != '0)) begin
            sel_s = SEL_POWER;
        end else if (pellet_eaten || (pend_pellet_r != '0)) begin
            sel_s = SEL_PELLET;
        end else begin
            sel_s = SEL_NONE;
        end
        idx_eff_s = (power_eaten || power_end) ? 2'd0 : idx_r;
        if (sel_s == SEL_GHOST) begin
            idx_nx_s = (idx_eff_s == 2'd3) ? 2'd3 : (idx_eff_s + 2'd1);
        end else begin
            idx_nx_s = idx_eff_s;
        end
    end

    // Award value mux.
    always_comb begin
        award_s     = '0;
        award_big_s = 1'b0;
        case (sel_s)
            SEL_GHOST: begin
                case (idx_eff_s)
                    2'd0:    begin award_s = GHOST0_BCD; award_big_s = GHOST0_BIG; end
                    2'd1:    begin award_s = GHOST1_BCD; award_big_s = GHOST1_BIG; end
                    2'd2:    begin award_s = GHOST2_BCD; award_big_s = GHOST2_BIG; end
                    default: begin award_s = GHOST3_BCD; award_big_s = GHOST3_BIG; end
                endcase
            end
            SEL_POWER:  begin award_s = POWER_BCD;  award_big_s = POWER_BIG;  end
            SEL_PELLET: begin award_s = PELLET_BCD; award_big_s = PELLET_BIG; end
            default:    begin award_s = '0;         award_big_s = 1'b0;       end
        endcase
    end

    // Next score, saturation, extra-life detection and pending-counter updates.
    always_comb begin
        sum_s       = bcd_add(score_r, award_s);
        sat_hit_s   = saturated_r | sum_s[W] | award_big_s;
        new_score_s = sat_hit_s ? NINES : sum_s[W-1:0];
        xl_hit_s    = armed_r & ~THRESH_BIG & (new_score_s >= THRESH_BCD);
        pellet_nx_s = pend_step(pend_pellet_r, pellet_eaten, sel_s == SEL_PELLET);
        power_nx_s  = pend_step(pend_power_r,  power_eaten,  sel_s == SEL_POWER);
        ghost_nx_s  = pend_step(pend_ghost_r,  ghost_eaten,  sel_s == SEL_GHOST);
    end

    // State register; game_clear wipes the game but keeps the high score.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_r       <= '0;
            high_r        <= '0;
            pend_pellet_r <= '0;
            pend_power_r  <= '0;
            pend_ghost_r  <= '0;
            idx_r         <= 2'd0;
            armed_r       <= 1'b1;
            saturated_r   <= 1'b0;
            extra_life_r  <= 1'b0;
            busy_r        <= 1'b0;
            dropped_r     <= 1'b0;
        end else if (game_clear) begin
            score_r       <= '0;
            pend_pellet_r <= '0;
            pend_power_r  <= '0;
            pend_ghost_r  <= '0;
            idx_r         <= 2'd0;
            armed_r       <= 1'b1;
            saturated_r   <= 1'b0;
            extra_life_r  <= 1'b0;
            busy_r        <= 1'b0;
            dropped_r     <= 1'b0;
        end else begin
            pend_pellet_r <= pellet_nx_s[PEND_W-1:0];
            pend_power_r  <= power_nx_s[PEND_W-1:0];
            pend_ghost_r  <= ghost_nx_s[PEND_W-1:0];
            idx_r         <= idx_nx_s;
            dropped_r     <= pellet_nx_s[PEND_W] | power_nx_s[PEND_W] | ghost_nx_s[PEND_W];
            busy_r        <= (pellet_nx_s[PEND_W-1:0] != '0) || (power_nx_s[PEND_W-1:0] != '0) ||
                             (ghost_nx_s[PEND_W-1:0] != '0);
            if (sel_s != SEL_NONE) begin
                score_r      <= new_score_s;
                saturated_r  <= sat_hit_s;
                extra_life_r <= xl_hit_s;
                armed_r      <= armed_r & ~xl_hit_s;
                if (new_score_s > high_r) begin
                    high_r <= new_score_s;
                end else begin
                    high_r <= high_r;
                end
            end else begin
                extra_life_r <= 1'b0;
            end
        end
    end

    assign score      = score_r;
    assign high_score = high_r;
    assign extra_life = extra_life_r;
    assign busy       = busy_r;
    assign saturated  = saturated_r;
    assign dropped    = dropped_r;

endmodule

// File: tb/tb_score_unit.sv
// Directed bench for score_unit: expected scores are queued at drive time and popped after each edge.
module tb_score_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        game_clear, pellet_eaten, power_eaten, ghost_eaten, power_end;
    logic [23:0] score, high_score;
    logic        extra_life, busy, saturated, dropped;
    logic        s_clear, s_pellet, s_zero;
    logic [7:0]  s_score, s_high;
    logic        s_xl, s_busy, s_sat, s_drop;
    int          checks = 0;
    int          failures = 0;
    int          exp_q[$];
    int          xl_count;
    int          sc;
    logic [23:0] tmp;

    always #5 Clk = ~Clk;

    score_unit u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .game_clear(game_clear),
        .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
        .ghost_eaten(ghost_eaten), .power_end(power_end),
        .score(score), .high_score(high_score), .extra_life(extra_life),
        .busy(busy), .saturated(saturated), .dropped(dropped)
    );

    score_unit #(.DIGITS(2)) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .game_clear(s_clear),
        .pellet_eaten(s_pellet), .power_eaten(s_zero),
        .ghost_eaten(s_zero), .power_end(s_zero),
        .score(s_score), .high_score(s_high), .extra_life(s_xl),
        .busy(s_busy), .saturated(s_sat), .dropped(s_drop)
    );

    function automatic logic [23:0] dec2bcd(input int v);
        logic [23:0] r;
        int          t;
        r = 24'h0;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One clock with the given strobes; pops and checks the next expected score if one is queued.
    task automatic cyc(input logic p, input logic pw, input logic g, input logic pe, input logic gc);
        @(negedge Clk);
        pellet_eaten = p;
        power_eaten  = pw;
        ghost_eaten  = g;
        power_end    = pe;
        game_clear   = gc;
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            chk("score", {8'h00, score}, {8'h00, dec2bcd(exp_q.pop_front())});
        end
        if (extra_life) begin
            xl_count++;
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        game_clear = 1'b0; pellet_eaten = 1'b0; power_eaten = 1'b0;
        ghost_eaten = 1'b0; power_end = 1'b0;
        s_clear = 1'b0; s_pellet = 1'b0; s_zero = 1'b0;
        xl_count = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_score", {8'h00, score}, 32'h0);
        chk("reset_high", {8'h00, high_score}, 32'h0);
        chk("reset_flags", {28'h0, extra_life, busy, saturated, dropped}, 32'h0);
        chk("reset_small", {24'h0, s_score}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Three single pellets: one-cycle latency, never busy.
        exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30);
        repeat (3) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("busy_single", {31'h0, busy}, 32'h0);
        end
        chk("high_30", {8'h00, high_score}, {8'h00, dec2bcd(30)});

        // Simultaneous pellet+power+ghost: ghost first, then power, then pellet.
        exp_q.push_back(0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("high_kept_on_clear", {8'h00, high_score}, {8'h00, dec2bcd(30)});
        exp_q.push_back(200); exp_q.push_back(250); exp_q.push_back(260);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("busy_q1", {31'h0, busy}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_q2", {31'h0, busy}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_q3", {31'h0, busy}, 32'h0);

        // Ghost chain: 200,400,800,1600,1600, chain restart, 200.
        exp_q.push_back(0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(200);  exp_q.push_back(600);  exp_q.push_back(1400);
        exp_q.push_back(3000); exp_q.push_back(4600); exp_q.push_back(4600);
        exp_q.push_back(4800);
        repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("high_4800", {8'h00, high_score}, {8'h00, dec2bcd(4800)});

        // Extra life: climb to 9990, cross 10000 once, no second pulse.
        exp_q.push_back(0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        xl_count = 0;
        for (int i = 1; i <= 999; i++) begin
            exp_q.push_back(i * 10);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("xl_before", xl_count, 32'd0);
        exp_q.push_back(10000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("xl_pulse", {31'h0, extra_life}, 32'h1);
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(10000 + i * 10);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("xl_after", {31'h0, extra_life}, 32'h0);
        chk("xl_count", xl_count, 32'd1);
        chk("high_10090", {8'h00, high_score}, {8'h00, dec2bcd(10090)});
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two-digit instance saturates at 99; game_clear clears it but keeps the high score.
        for (int i = 1; i <= 11; i++) begin
            @(negedge Clk);
            s_pellet = 1'b1;
            @(posedge Clk);
            #1;
            tmp = dec2bcd(i * 10);
            chk("small_score", {24'h0, s_score}, (i < 10) ? {24'h0, tmp[7:0]} : 32'h99);
            chk("small_sat", {31'h0, s_sat}, (i >= 10) ? 32'h1 : 32'h0);
        end
        @(negedge Clk);
        s_pellet = 1'b0;
        s_clear  = 1'b1;
        @(posedge Clk);
        #1;
        chk("small_clr_score", {24'h0, s_score}, 32'h0);
        chk("small_clr_sat", {31'h0, s_sat}, 32'h0);
        chk("small_high", {24'h0, s_high}, 32'h99);
        @(negedge Clk);
        s_clear = 1'b0;

        // Pellet+ghost held: ghosts consumed directly, pellets queue to 15 then drop.
        exp_q.push_back(0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sc = 0;
        for (int k = 1; k <= 20; k++) begin
            sc = sc + ((k == 1) ? 200 : (k == 2) ? 400 : (k == 3) ? 800 : 1600);
            exp_q.push_back(sc);
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("dropped", {31'h0, dropped}, (k > 15) ? 32'h1 : 32'h0);
            chk("busy_hold", {31'h0, busy}, 32'h1);
        end
        exp_q.push_back(sc + 10); exp_q.push_back(sc + 20); exp_q.push_back(sc + 30);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_drain", {31'h0, busy}, 32'h1);
        chk("drop_gone", {31'h0, dropped}, 32'h0);

        // Asynchronous reset mid-drain.
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_score", {8'h00, score}, 32'h0);
        chk("async_high", {8'h00, high_score}, 32'h0);
        chk("async_flags", {28'h0, extra_life, busy, saturated, dropped}, 32'h0);
        chk("async_small", {24'h0, s_score, s_high}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_score", {8'h00, score}, 32'h0);
        chk("post_reset_busy", {31'h0, busy}, 32'h0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
